// File: rtl/dds_voice_bank_if.sv
// Bus between the SPI command decoder, the voice bank and the DAC serializer.
// Handshake: cfg_we is a one-cycle write strobe that is always accepted (no
// ready); sample_valid is a one-cycle pulse marking a new sample_out, and the
// consumer must take it in that cycle (no backpressure).
interface dds_voice_bank_if #(
  parameter int NUM_VOICES = 4,
  parameter int TUNE_W     = 16,
  parameter int WAVE_W     = 12
);
  localparam int VID_W = $clog2(NUM_VOICES);
  localparam int SUM_W = WAVE_W + VID_W;

  logic              cfg_we;
  logic [VID_W-1:0]  cfg_voice;
  logic [1:0]        cfg_field;
  logic [TUNE_W-1:0] cfg_data;
  logic [SUM_W-1:0]  sample_out;
  logic              sample_valid;

  modport master (
    output cfg_we, cfg_voice, cfg_field, cfg_data,
    input  sample_out, sample_valid
  );

  modport slave (
    input  cfg_we, cfg_voice, cfg_field, cfg_data,
    output sample_out, sample_valid
  );
endinterface

// File: rtl/dds_voice_bank.sv
// Time-multiplexed DDS bank: one shared phase adder / waveform generator
// serves NUM_VOICES accumulators in round-robin slots; the voices of a frame
// are summed into one mixed sample.
module dds_voice_bank #(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 16,
  parameter int TUNE_W     = 16,
  parameter int WAVE_W     = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  dds_voice_bank_if.slave        bus
);
  localparam int VID_W = $clog2(NUM_VOICES);
  localparam int SUM_W = WAVE_W + VID_W;
  localparam logic [VID_W-1:0] LAST_VID = VID_W'(NUM_VOICES - 1);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  logic [TUNE_W-1:0]  tune_q  [NUM_VOICES];
  logic [TUNE_W-1:0]  tune_d  [NUM_VOICES];
  logic               en_q    [NUM_VOICES];
  logic               en_d    [NUM_VOICES];
  logic [1:0]         sel_q   [NUM_VOICES];
  logic [1:0]         sel_d   [NUM_VOICES];
  logic [WAVE_W-1:0]  pw_q    [NUM_VOICES];
  logic [WAVE_W-1:0]  pw_d    [NUM_VOICES];
  logic [PHASE_W-1:0] phase_q [NUM_VOICES];
  logic [PHASE_W-1:0] phase_d [NUM_VOICES];

  logic [VID_W-1:0]   vid_q, vid_d;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [SUM_W-1:0]   sample_out_q, sample_out_d;
  logic               sample_valid_q, sample_valid_d;

  logic [WAVE_W-1:0]  p;
  logic [WAVE_W-1:0]  tri_w;
  logic [WAVE_W-1:0]  w;

  // Waveform for the voice in the current slot, from its pre-update phase.
  always_comb begin
    p     = phase_q[vid_q][PHASE_W-1 -: WAVE_W];
    tri_w = {p[WAVE_W-2:0], 1'b0};
    if (p[WAVE_W-1]) tri_w = ~tri_w;
    w = '0;
    if (en_q[vid_q]) begin
      case (sel_q[vid_q])
        2'd0:    w = p;
        2'd1:    w = (p < pw_q[vid_q]) ? '1 : '0;
        2'd2:    w = tri_w;
        default: w = lfsr_q[15 -: WAVE_W];
      endcase
    end
  end

  // Slot sequencing, phase update, mixing, then config writes on top so a
  // phase reset to the current voice wins over its increment.
  always_comb begin
    tune_d         = tune_q;
    en_d           = en_q;
    sel_d          = sel_q;
    pw_d           = pw_q;
    phase_d        = phase_q;
    vid_d          = vid_q;
    acc_d          = acc_q;
    lfsr_d         = lfsr_q;
    sample_out_d   = sample_out_q;
    sample_valid_d = 1'b0;

    if (run) begin
      vid_d = vid_q + VID_W'(1);
      if (en_q[vid_q]) begin
        phase_d[vid_q] = phase_q[vid_q] + PHASE_W'(tune_q[vid_q]);
      end
      if (vid_q == '0) acc_d = SUM_W'(w);
      else             acc_d = acc_q + SUM_W'(w);
      if (vid_q == LAST_VID) begin
        sample_out_d   = acc_q + SUM_W'(w);
        sample_valid_d = 1'b1;
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end
    end

    if (bus.cfg_we) begin
      case (bus.cfg_field)
        2'd0: tune_d[bus.cfg_voice] = bus.cfg_data;
        2'd1: begin
          sel_d[bus.cfg_voice] = bus.cfg_data[1:0];
          en_d[bus.cfg_voice]  = bus.cfg_data[2];
        end
        2'd2:    pw_d[bus.cfg_voice]    = bus.cfg_data[WAVE_W-1:0];
        default: phase_d[bus.cfg_voice] = '0;
      endcase
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        tune_q[i]  <= '0;
        en_q[i]    <= 1'b0;
        sel_q[i]   <= '0;
        pw_q[i]    <= WAVE_W'(1) << (WAVE_W - 1);
        phase_q[i] <= '0;
      end
      vid_q          <= '0;
      acc_q          <= '0;
      lfsr_q         <= LFSR_SEED;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      tune_q         <= tune_d;
      en_q           <= en_d;
      sel_q          <= sel_d;
      pw_q           <= pw_d;
      phase_q        <= phase_d;
      vid_q          <= vid_d;
      acc_q          <= acc_d;
      lfsr_q         <= lfsr_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign bus.sample_out   = sample_out_q;
  assign bus.sample_valid = sample_valid_q;
endmodule

// File: doc/dds_voice_bank.md
# dds_voice_bank

Time-multiplexed N-voice DDS core: one shared phase adder and waveform generator service `NUM_VOICES` phase accumulators in round-robin slots, and the voice outputs are summed into one mixed sample per frame. It replaces the pair of fixed two-voice oscillators with a single parametrised bank. It sits between the SPI command decoder, which drives the `cfg_*` port, and the DAC SPI serializer, which consumes `sample_out` on `sample_valid`.

## Interface
- `NUM_VOICES`, 4: voice count; must be a power of 2 and at least 2.
- `PHASE_W`, 16: phase accumulator width.
- `TUNE_W`, 16: tuning word and `cfg_data` width; TUNE_W ≤ PHASE_W and TUNE_W ≥ WAVE_W.
- `WAVE_W`, 12: per-voice waveform width, unsigned.
- Derived widths: VID_W = clog2(NUM_VOICES); SUM_W = WAVE_W + VID_W.

- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  slot advance enable; when low, all sequencing freezes.
- `cfg_we`  in  1  config write strobe, one cycle.
- `cfg_voice`  in  VID_W  target voice.
- `cfg_field`  in  2  0 = tune, 1 = mode, 2 = pulse width, 3 = phase reset.
- `cfg_data`  in  TUNE_W  write data.
- `sample_out`  out  SUM_W  mixed sample, held between updates.
- `sample_valid`  out  1  one-cycle pulse when `sample_out` updates.

## Operation
- Per-voice registers:
  - `tune`: TUNE_W bits.
  - `en`: 1 bit.
  - `sel`: 2 bits.
  - `pw`: WAVE_W bits.
  - `phase`: PHASE_W bits.
- Config writes:
  - Field 0: `tune` ← `cfg_data`.
  - Field 1: `sel` ← `cfg_data[1:0]`; `en` ← `cfg_data[2]`.
  - Field 2: `pw` ← `cfg_data[WAVE_W-1:0]`.
  - Field 3: `phase` ← 0.
- Slot counter `vid` steps 0 → NUM_VOICES-1 and wraps. It advances once per `clk` while `run` is 1. One full cycle of `vid` is a frame.
- In the slot for voice v (run = 1):
  - p = `phase[v][PHASE_W-1 -: WAVE_W]`, taken from the pre-update phase.
  - If `en[v]`: `phase[v]` ← `phase[v]` + zero-extended `tune[v]`, modulo 2^PHASE_W (wraps silently).
  - If not `en[v]`: phase holds and the voice contributes 0.
- Waveform `w` by `sel`:
  - 0, saw: p.
  - 1, square: all-ones if p < `pw[v]`, else 0.
  - 2, triangle: `{p[WAVE_W-2:0], 0}` if p MSB is 0, else the bitwise inverse of that value.
  - 3, noise: top WAVE_W bits of the shared 16-bit LFSR.
- LFSR:
  - Fibonacci taps 16, 14, 13, 11.
  - Steps once per frame, in slot NUM_VOICES-1.
  - Seed 16'hACE1.
- Mixing:
  - Slot 0: `acc` ← `w`.
  - Other slots: `acc` ← `acc` + `w`.
  - Slot NUM_VOICES-1: `sample_out` ← `acc` + `w` and `sample_valid` pulses.
  - SUM_W bits cannot overflow, so no saturation is applied.
- `run` = 0: `vid`, `acc`, every `phase`, and the LFSR hold; `sample_valid` = 0. Config writes are still accepted.
- Config write to the voice in the current slot, same cycle: the slot computes from the pre-write values and the write lands at the edge. For field 3, the phase reset overrides the increment, so `phase` = 0 afterwards.
- Write to any other voice: takes effect in that voice's next slot.

## Timing
- Reset values: all `phase`, `tune`, `en`, `sel` = 0; `pw` = 2^(WAVE_W-1); LFSR = 16'hACE1; `vid` = 0; `acc` = 0; `sample_out` = 0; `sample_valid` = 0.
- Reset asserted mid-frame clears everything immediately. The first frame after release starts at slot 0.
- Sample rate with continuous `run` = clk / NUM_VOICES.
- `sample_valid` is high in the cycle after the slot NUM_VOICES-1 edge, which is cycle NUM_VOICES counted from the frame's slot-0 cycle.
- Sample k reflects phases before frame k's increments: the first sample after reset uses phase 0.
- No combinational path from any input to any output.

## Test plan
Defaults apply: 4 voices, PHASE_W 16, WAVE_W 12, `run` = 1.

1. Reset check: during and after reset, with no writes, `sample_out` = 0. `sample_valid` pulses every 4th cycle with value 0x0000.
2. Saw and wrap: voice 0 tune = 0x1000, mode = saw + en. Samples read 0x000, 0x100, …, 0xF00, then 0x000 on frame 17, after the phase wrap.
3. Square and triangle:
   - Voice 1 square, pw = 0x800, tune = 0x4000: samples 0xFFF, 0xFFF, 0x000, 0x000 repeating.
   - Re-run with triangle, tune = 0x2000: samples 0x000, 0x400, 0x800, 0xC00, 0xFFF, 0xBFF, …
4. Full-scale mix: all four voices square, pw = 0xFFF, tune = 0, en. Every sample = 0x3FFC, with no wrap.
5. Same-slot collisions:
   - Phase reset written in voice 0's slot, voice 0 saw at 0x1000: the next sample returns to 0x000.
   - A tune write in that slot affects only the following frame.
6. Run freeze and reset mid-frame:
   - Drop `run` for 7 cycles mid-frame: no `sample_valid`, and the sample sequence continues unchanged once `run` returns.
   - Assert `rst_n` low mid-frame: all outputs are 0, and the next sample is 0x000.
